// File: rtl/utf8_pkg.sv
// utf8_pkg: shared types and constants for the UTF-8 byte serializer and
// any future UTF-8 decoder.
//   state_t  - serializer FSM states (IDLE, SEND)
//   len_t    - character length, encoded as length-1 (0..3)
//   LEADn_*  - lead-byte mask/match pairs for the 1/2/3/4-byte forms
//   UTF8_REPLACEMENT_BYTES - U+FFFD packed byte 0 first (EF BF BD)
package utf8_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [1:0] len_t;

    // A lead byte has the form n when (byte & MASK) == MATCH.
    localparam logic [7:0] LEAD1_MASK  = 8'h80;
    localparam logic [7:0] LEAD1_MATCH = 8'h00;
    localparam logic [7:0] LEAD2_MASK  = 8'hE0;
    localparam logic [7:0] LEAD2_MATCH = 8'hC0;
    localparam logic [7:0] LEAD3_MASK  = 8'hF0;
    localparam logic [7:0] LEAD3_MATCH = 8'hE0;
    localparam logic [7:0] LEAD4_MASK  = 8'hF8;
    localparam logic [7:0] LEAD4_MATCH = 8'hF0;

    localparam logic [31:0] UTF8_REPLACEMENT_BYTES = 32'h00BDBFEF;
    localparam len_t        UTF8_REPLACEMENT_LEN   = 2'd2;

endpackage

// File: rtl/utf8_length_decode.sv
// utf8_length_decode: purely combinational lead-byte classifier.
// Ports:
//   lead_byte  in  8  byte 0 of an encoded character
//   len_minus1 out 2  character length minus one (0 when malformed)
//   malformed  out 1  lead byte matches none of the 1..4 byte forms
module utf8_length_decode
    import utf8_pkg::*;
(
    input  logic [7:0] lead_byte,
    output len_t       len_minus1,
    output logic       malformed
);

    always_comb begin
        len_minus1 = 2'd0;
        malformed  = 1'b0;
        if ((lead_byte & LEAD1_MASK) == LEAD1_MATCH) begin
            len_minus1 = 2'd0;
        end else if ((lead_byte & LEAD2_MASK) == LEAD2_MATCH) begin
            len_minus1 = 2'd1;
        end else if ((lead_byte & LEAD3_MASK) == LEAD3_MATCH) begin
            len_minus1 = 2'd2;
        end else if ((lead_byte & LEAD4_MASK) == LEAD4_MATCH) begin
            len_minus1 = 2'd3;
        end else begin
            // Continuation bytes (10xxxxxx) and F8..FF cannot start a character.
            malformed = 1'b1;
        end
    end

endmodule

// File: rtl/utf8_byte_serializer.sv
// utf8_byte_serializer: takes one packed UTF-8 word per transaction and
// emits its bytes one per cycle, flagging the last byte of each character.
// Invalid words (encoder status set or malformed lead byte) pulse err_pulse
// for one cycle and bump a saturating counter.
//
// Optional feature macro UTF8_BYTE_SERIALIZER_REPLACEMENT_EN:
//   defined   - an invalid word is replaced by U+FFFD (EF BF BD)
//   undefined - an invalid word is dropped from the stream
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   in_valid/ready  word handshake; in_bytes packed byte 0 at [7:0]
//   in_status       1 = encoder reported an invalid codepoint
//   out_valid/ready byte handshake; out_byte, out_last (final byte of char)
//   err_pulse       one cycle after an invalid word is accepted
//   err_count       saturating count of invalid words
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A source holds valid and its payload stable until the transfer; ready may
// depend on state and, for in_ready only, on out_ready in the last-byte cycle.
module utf8_byte_serializer
    import utf8_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_bytes,
    input  logic                 in_status,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_byte,
    output logic                 out_last,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_t      state, state_next;
    logic [31:0] hold, hold_next;
    len_t        len_m1, len_next;
    len_t        idx, idx_next;

    len_t        dec_len_m1;
    logic        dec_malformed;
    logic        word_err;
    logic        accept;
    logic        err_event;

    utf8_length_decode u_len_decode (
        .lead_byte  (in_bytes[7:0]),
        .len_minus1 (dec_len_m1),
        .malformed  (dec_malformed)
    );

    assign word_err  = in_status | dec_malformed;

    // Outputs are driven from registered state only, so in_valid never
    // reaches out_*.
    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && (idx == len_m1);
    assign out_byte  = (state == SEND) ? hold[{idx, 3'b000} +: 8] : 8'h00;

    // Accept a new word when idle, or in the last-byte handshake cycle so
    // characters stream back to back without a bubble.
    assign in_ready  = (state == IDLE) || (out_last && out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_next = state;
        hold_next  = hold;
        len_next   = len_m1;
        idx_next   = idx;
        err_event  = 1'b0;

        if (state == SEND && out_ready) begin
            if (out_last) begin
                state_next = IDLE;
            end else begin
                idx_next = len_t'(idx + 2'd1);
            end
        end

        if (accept) begin
            idx_next = 2'd0;
            if (word_err) begin
                err_event = 1'b1;
`ifdef UTF8_BYTE_SERIALIZER_REPLACEMENT_EN
                state_next = SEND;
                hold_next  = UTF8_REPLACEMENT_BYTES;
                len_next   = UTF8_REPLACEMENT_LEN;
`else
                state_next = IDLE;
`endif
            end else begin
                state_next = SEND;
                hold_next  = in_bytes;
                len_next   = dec_len_m1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            hold   <= 32'h0;
            len_m1 <= 2'd0;
            idx    <= 2'd0;
        end else begin
            state  <= state_next;
            hold   <= hold_next;
            len_m1 <= len_next;
            idx    <= idx_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= err_event;
            if (err_event && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
